// File: rtl/shift_sequencer_pkg.sv
// Shared types and opcode constants for the multi-step shift sequencer.
package shift_seq_pkg;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} seq_state_t;

   localparam logic [1:0] SH_PASS = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   typedef logic [15:0] word_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response handshake bundle between the control FSM and the sequencer.
interface shift_sequencer_if #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_data;
   logic [1:0]       req_op;
   logic [AMT_W-1:0] req_amt;
   logic             abort;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             busy;

   // Requester / result consumer side.
   modport master (
      output req_valid, req_data, req_op, req_amt, abort, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, busy
   );

   // Sequencer side.
   modport slave (
      input  req_valid, req_data, req_op, req_amt, abort, rsp_ready,
      output req_ready, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/shift_sequencer_shifter.sv
// Existing single-step 16-bit shifter: pass, LSL 1, LSR 1, ASR 1. Purely combinational.
module shifter
   import shift_seq_pkg::*;
(
   input  word_t      in,
   input  logic [1:0] shift,
   output word_t      sout
);

   // One-position shift selected by the opcode; zero fill except ASR.
   always_comb begin
      sout = in;
      case (shift)
         SH_LSL:  sout = {in[14:0], 1'b0};
         SH_LSR:  sout = {1'b0, in[15:1]};
         SH_ASR:  sout = {in[15], in[15:1]};
         default: sout = in;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift sequencer: accepts one request, drives the single-step
// shifter once per clock for req_amt steps, then holds the result until taken.
// Only WIDTH=16 is supported because the shifter is fixed at 16 bits.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   shift_sequencer_if.slave  bus
);

   seq_state_t       state;
   seq_state_t       state_nx;
   logic [WIDTH-1:0] data;
   logic [1:0]       op;
   logic [AMT_W-1:0] cnt;
   word_t            sh_out;

   // A request needs stepping only when it actually moves bits.
   logic             req_moves;
   assign req_moves = (bus.req_op != SH_PASS) && (bus.req_amt != '0);

   shifter u_shifter (
      .in    (data),
      .shift (op),
      .sout  (sh_out)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state decode; abort wins over the final step so an aborted shift never responds.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.req_valid) state_nx = req_moves ? S_SHIFT : S_DONE;
         S_SHIFT: begin
            if (bus.abort)                 state_nx = S_IDLE;
            else if (cnt == AMT_W'(1))     state_nx = S_DONE;
         end
         S_DONE:  if (bus.rsp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Operand capture and per-step update; cnt only decrements while nonzero in SHIFT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         op   <= SH_PASS;
         cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  data <= bus.req_data;
                  op   <= bus.req_op;
                  cnt  <= req_moves ? bus.req_amt : '0;
               end
            end
            S_SHIFT: begin
               if (bus.abort) begin
                  cnt <= '0;
               end else begin
                  data <= sh_out;
                  cnt  <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = (state == S_IDLE);
   assign bus.rsp_valid = (state == S_DONE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.rsp_data  = data;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed corner cases followed by
// randomized back-to-back requests against a plain-arithmetic shift model.
module tb_shift_sequencer;
   import shift_seq_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   shift_sequencer_if #(.WIDTH(16), .AMT_W(4)) bus ();

   shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: whole multi-bit shift computed in one expression.
   function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] op, input int amt);
      logic signed [15:0] s;
      s = d;
      if (op == SH_PASS || amt == 0) return d;
      case (op)
         SH_LSL:  return d << amt;
         SH_LSR:  return d >> amt;
         default: return s >>> amt;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge with the DUT idle. Returns just after the
   // negedge following the response handshake.
   task automatic do_req(input string tag, input logic [15:0] d, input logic [1:0] op,
                         input logic [3:0] amt, input int hold);
      logic [15:0] exp;
      int          k;
      int          lat;
      bit          seen;
      exp  = model(d, op, int'(amt));
      k    = (op == SH_PASS) ? 0 : int'(amt);
      check({tag, "_ready_idle"}, bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_data  = d;
      bus.req_op    = op;
      bus.req_amt   = amt;
      lat  = 0;
      seen = 0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         bus.req_valid = 1'b0;
         bus.req_data  = 16'($urandom);
         check({tag, "_ready_low"}, bus.req_ready, 0);
         if (bus.rsp_valid === 1'b1) seen = 1;
      end
      check({tag, "_valid"}, bus.rsp_valid, 1);
      check({tag, "_latency"}, lat, k + 1);
      check({tag, "_data"}, bus.rsp_data, exp);
      check({tag, "_busy"}, bus.busy, 1);
      for (int h = 0; h < hold; h++) begin
         bus.rsp_ready = 1'b0;
         @(negedge clk);
         check({tag, "_hold_valid"}, bus.rsp_valid, 1);
         check({tag, "_hold_data"}, bus.rsp_data, exp);
         check({tag, "_hold_ready"}, bus.req_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check({tag, "_post_ready"}, bus.req_ready, 1);
      check({tag, "_post_valid"}, bus.rsp_valid, 0);
      check({tag, "_post_busy"}, bus.busy, 0);
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_data  = '0;
      bus.req_op    = SH_PASS;
      bus.req_amt   = '0;
      bus.abort     = 1'b0;
      bus.rsp_ready = 1'b0;

      // Reset values.
      #12;
      check("rst_ready", bus.req_ready, 1);
      check("rst_valid", bus.rsp_valid, 0);
      check("rst_data",  bus.rsp_data, 0);
      check("rst_busy",  bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic four-step shifts of F0CF.
      do_req("lsl4", 16'hF0CF, SH_LSL, 4'd4, 0);
      check("lsl4_const", model(16'hF0CF, SH_LSL, 4), 16'h0CF0);
      do_req("lsr4", 16'hF0CF, SH_LSR, 4'd4, 0);
      do_req("asr4", 16'hF0CF, SH_ASR, 4'd4, 0);

      // Degenerate amounts and full-range shifts.
      do_req("amt0",   16'hF0CF, SH_LSL,  4'd0,  0);
      do_req("pass7",  16'hF0CF, SH_PASS, 4'd7,  0);
      do_req("asr15",  16'h8000, SH_ASR,  4'd15, 0);
      do_req("lsl15",  16'hF0CF, SH_LSL,  4'd15, 0);

      // Back-pressure in DONE.
      do_req("bp3", 16'h1234, SH_LSR, 4'd3, 3);

      // Abort when cnt reaches 2 in a 5-step shift.
      bus.req_valid = 1'b1;
      bus.req_data  = 16'hA5A5;
      bus.req_op    = SH_LSL;
      bus.req_amt   = 4'd5;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_pre_busy", bus.busy, 1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_ready", bus.req_ready, 1);
      check("abort_valid", bus.rsp_valid, 0);
      check("abort_busy",  bus.busy, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_no_rsp", bus.rsp_valid, 0);
      end
      do_req("after_abort", 16'h00F1, SH_ASR, 4'd2, 1);

      // Asynchronous reset in the middle of a shift.
      bus.req_valid = 1'b1;
      bus.req_data  = 16'h5555;
      bus.req_op    = SH_LSR;
      bus.req_amt   = 4'd10;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_busy", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ready", bus.req_ready, 1);
      check("mid_rst_valid", bus.rsp_valid, 0);
      check("mid_rst_data",  bus.rsp_data, 0);
      check("mid_rst_busy",  bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_req("after_rst", 16'h8421, SH_LSL, 4'd6, 0);

      // Randomized back-to-back traffic.
      for (int n = 0; n < 200; n++) begin
         do_req("rand", 16'($urandom), 2'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
